// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU for the MIPS EX stage.
//
// Single-cycle ops: ADD(010) SUB(110) AND(000) OR(001) SLT(111, signed).
// Iterative ops:    MUL(100, low WIDTH bits) DIVU(011) REMU(101).
// The iterative datapath exists only when the macro MULDIV_EN is defined.
// Without it, MUL/DIVU/REMU finish in one cycle with result=0, zero=1, illegal=1.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid & ready are both high. The producer holds a/b/aluop and in_valid
// until it is accepted. The unit holds result and all flags in DONE until
// the consumer takes them. A result can retire and a new op can be accepted
// on the same edge.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, aluop)
//   out_valid / out_ready result handshake (result, zero, div0, illegal)
//   dbg_state_o          current FSM state (0 IDLE, 1 CALC, 2 DONE)
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div0,
    output logic             illegal,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;
    logic             ill_q, ill_d;
    logic             accept;
    logic             is_multi;
    logic [WIDTH-1:0] single_res;

`ifdef MULDIV_EN
    localparam int CW = $clog2(WIDTH);

    // Shared iteration registers:
    //   MUL : x = shifted multiplicand, y = shifted multiplier, acc = product
    //   DIV : x = dividend shifting out / quotient shifting in, y = divisor,
    //         acc = partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mul_acc_n;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_rem_n;
    logic [WIDTH-1:0] div_quo_n;
    logic [WIDTH-1:0] calc_res;
`endif

    assign in_ready    = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept      = in_valid & in_ready;
    assign out_valid   = (state_q == DONE);
    assign result      = res_q;
    assign zero        = zero_q;
    assign div0        = div0_q;
    assign illegal     = ill_q;
    assign dbg_state_o = state_q;
    assign is_multi    = (aluop == OP_MUL) | (aluop == OP_DIVU) | (aluop == OP_REMU);

    always_comb begin
        single_res = '0;
        case (aluop)
            OP_AND:  single_res = a & b;
            OP_OR:   single_res = a | b;
            OP_ADD:  single_res = a + b;
            OP_SUB:  single_res = a - b;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: single_res = '0;
        endcase
    end

`ifdef MULDIV_EN
    always_comb begin
        mul_acc_n = acc_q + (y_q[0] ? x_q : '0);
        // Shift the next dividend bit into the remainder and try subtracting.
        // The remainder is always below the divisor, so WIDTH+1 bits suffice.
        div_trial = {acc_q, x_q[WIDTH-1]} - {1'b0, y_q};
        if (!div_trial[WIDTH]) begin
            div_rem_n = div_trial[WIDTH-1:0];
            div_quo_n = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_n = {acc_q[WIDTH-2:0], x_q[WIDTH-1]};
            div_quo_n = {x_q[WIDTH-2:0], 1'b0};
        end
        case (op_q)
            OP_MUL:  calc_res = mul_acc_n;
            OP_DIVU: calc_res = div_quo_n;
            default: calc_res = div_rem_n;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        div0_d  = div0_q;
        ill_d   = ill_q;
`ifdef MULDIV_EN
        cnt_d   = cnt_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
`endif

        case (state_q)
            IDLE: ;
            CALC: begin
`ifdef MULDIV_EN
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_n;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = div_rem_n;
                    x_d   = div_quo_n;
                end
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    res_d   = calc_res;
                    zero_d  = (calc_res == '0);
                end
`else
                state_d = IDLE;
`endif
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the DONE retire path so a new op follows
        // the old result without an idle cycle.
        if (accept) begin
            div0_d = 1'b0;
            ill_d  = 1'b0;
            if (!is_multi) begin
                state_d = DONE;
                res_d   = single_res;
                zero_d  = (single_res == '0);
            end else begin
`ifdef MULDIV_EN
                if ((aluop != OP_MUL) && (b == '0)) begin
                    state_d = DONE;
                    div0_d  = 1'b1;
                    res_d   = (aluop == OP_DIVU) ? '1 : a;
                    zero_d  = (aluop == OP_DIVU) ? 1'b0 : (a == '0);
                end else begin
                    state_d = CALC;
                    op_d    = aluop;
                    cnt_d   = '0;
                    x_d     = a;
                    y_d     = b;
                    acc_d   = '0;
                end
`else
                state_d = DONE;
                res_d   = '0;
                zero_d  = 1'b1;
                ill_d   = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            div0_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            div0_q  <= div0_d;
            ill_q   <= ill_d;
        end
    end

`ifdef MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32). Expectations for MUL/DIVU/REMU
// follow whichever build is compiled (MULDIV_EN defined or not).
module tb_alu_mc;

`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  aluop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        div0;
  logic        illegal;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int rdy_bad;

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .aluop      (aluop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .div0       (div0),
    .illegal    (illegal),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait for acceptance, then count edges until out_valid.
  // The accept edge counts as latency 1. out_ready stays 0 so DONE holds.
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    int guard;
    aluop    = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    lat      = 1;
    rdy_bad  = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_bad++;
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    aluop     = 3'b000;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_result",    result,             32'd0);
    chk("rst_flags",     {29'd0, zero, div0, illegal}, 32'd0);
    chk("rst_state",     {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. ADD wrap, SUB negative
    run_op(3'b010, 32'hFFFF_FFFF, 32'd1);
    chk("add_lat",    lat, 32'd1);
    chk("add_result", result, 32'd0);
    chk("add_zero",   {31'd0, zero}, 32'd1);
    retire();
    run_op(3'b110, 32'd5, 32'd7);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_zero",   {31'd0, zero}, 32'd0);
    retire();
    chk("idle_state", {30'd0, dbg_state}, 32'd0);

    // 2. SLT signed
    run_op(3'b111, 32'hFFFF_FFFF, 32'd1);
    chk("slt_neg_result", result, 32'd1);
    retire();
    run_op(3'b111, 32'd1, 32'hFFFF_FFFF);
    chk("slt_pos_result", result, 32'd0);
    chk("slt_pos_zero",   {31'd0, zero}, 32'd1);
    retire();
    run_op(3'b001, 32'h0000_F000, 32'h0000_000F);
    chk("or_result", result, 32'h0000_F00F);
    retire();

    // 3. MUL
    run_op(3'b100, 32'h0001_2345, 32'h0001_0000);
    chk("mul_lat",     lat, MD ? 32'd33 : 32'd1);
    chk("mul_busy",    rdy_bad, 32'd0);
    chk("mul_result",  result, MD ? 32'h2345_0000 : 32'd0);
    chk("mul_illegal", {31'd0, illegal}, MD ? 32'd0 : 32'd1);
    retire();
    run_op(3'b100, 32'hFFFF_FFFD, 32'd7);
    chk("mul_signed_result", result, MD ? 32'hFFFF_FFEB : 32'd0);
    retire();

    // 4. DIVU / REMU
    run_op(3'b011, 32'd100, 32'd7);
    chk("divu_lat",    lat, MD ? 32'd33 : 32'd1);
    chk("divu_result", result, MD ? 32'd14 : 32'd0);
    retire();
    run_op(3'b101, 32'd100, 32'd7);
    chk("remu_result", result, MD ? 32'd2 : 32'd0);
    chk("remu_zero",   {31'd0, zero}, MD ? 32'd0 : 32'd1);
    retire();
    run_op(3'b011, 32'hFFFF_FFFF, 32'd3);
    chk("divu_big_result", result, MD ? 32'h5555_5555 : 32'd0);
    retire();
    run_op(3'b011, 32'd9, 32'd0);
    chk("div0_lat",     lat, 32'd1);
    chk("div0_result",  result, MD ? 32'hFFFF_FFFF : 32'd0);
    chk("div0_flag",    {31'd0, div0}, MD ? 32'd1 : 32'd0);
    chk("div0_illegal", {31'd0, illegal}, MD ? 32'd0 : 32'd1);
    retire();
    run_op(3'b101, 32'd9, 32'd0);
    chk("rem0_result", result, MD ? 32'd9 : 32'd0);
    chk("rem0_flag",   {31'd0, div0}, MD ? 32'd1 : 32'd0);
    retire();

    // 5. DONE hold, then back-to-back retire + accept
    run_op(3'b110, 32'd5, 32'd7);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid",  {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, 32'hFFFF_FFFE);
      chk("hold_ready",  {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    aluop     = 3'b000;
    a         = 32'h0000_00F0;
    b         = 32'h0000_003C;
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_valid",  {31'd0, out_valid}, 32'd1);
    chk("b2b_result", result, 32'h0000_0030);
    chk("b2b_flags",  {29'd0, zero, div0, illegal}, 32'd0);
    retire();

    // 6. reset mid-MUL
    aluop    = 3'b100;
    a        = 32'd3;
    b        = 32'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_state", {30'd0, dbg_state}, MD ? 32'd1 : 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
    chk("mid_rst_result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(3'b010, 32'd2, 32'd3);
    chk("post_rst_lat",    lat, 32'd1);
    chk("post_rst_result", result, 32'd5);
    retire();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
